// File: rtl/bambu_mem_pkg.sv
// Shared types, default geometry and the size-mask helper for the Bambu memory master.
package bambu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ADDR_W_DEF         = 7;
  localparam int DATA_W_DEF         = 8;
  localparam int SIZE_W_DEF         = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  // One bit of the access-size mask: bit bit_idx survives when it lies below size.
  // Evaluated per bit so the mask scales with any data width.
  function automatic logic size_to_mask(input int size, input int bit_idx);
    return (bit_idx < size);
  endfunction

endpackage

// File: rtl/bambu_mem_timeout_cnt.sv
// BUSY-cycle watchdog for the Bambu memory master; used only with BAMBU_MEM_MASTER_TIMEOUT_EN.
module bambu_mem_timeout_cnt
  import bambu_mem_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_reg;

  // expired flags the LIMIT-th enabled cycle, so the caller can leave on that edge
  assign expired = enable && (cnt_reg == CNT_W'(LIMIT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && !expired) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bambu_mem_master.sv
// Single-outstanding request/response master for the Bambu memory bus.
// Optional BUSY watchdog is enabled by defining BAMBU_MEM_MASTER_TIMEOUT_EN.
module bambu_mem_master
  import bambu_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SIZE_W         = SIZE_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SIZE_W-1:0] req_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy
);

  state_t state_reg, state_next;

  logic              oe_reg, oe_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [SIZE_W-1:0] size_reg, size_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;

  logic              accept;
  logic              size_bad;
  logic              timeout_hit;
  logic [DATA_W-1:0] rd_mask;

  // req_ready is gated by reset so the master never advertises readiness while held
  assign req_ready = (state_reg == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign size_bad  = (req_size == '0) || (int'(req_size) > DATA_W);
  assign rsp_valid = (state_reg == RESP);

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rd_mask
      assign rd_mask[gi] = size_to_mask(int'(size_reg), gi);
    end
  endgenerate

`ifdef BAMBU_MEM_MASTER_TIMEOUT_EN
  bambu_mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_reg != BUSY),
    .enable  (state_reg == BUSY),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  // Without the watchdog the limit has no consumer; keep it referenced as an elaboration-time sanity guard.
  if (TIMEOUT_CYCLES < 1) begin : g_unused_timeout
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = size_bad ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (M_DataRdy || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oe_next    = oe_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    size_next  = size_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept && size_bad) begin
          err_next   = 1'b1;
          rdata_next = '0;
        end else if (accept) begin
          // the two strobes come from one bit, so they can never overlap
          oe_next    = ~req_we;
          we_next    = req_we;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          size_next  = req_size;
          err_next   = 1'b0;
          rdata_next = '0;
        end
      end
      BUSY: begin
        if (M_DataRdy) begin
          oe_next    = 1'b0;
          we_next    = 1'b0;
          err_next   = 1'b0;
          rdata_next = oe_reg ? (M_Rdata_ram & rd_mask) : '0;
        end else if (timeout_hit) begin
          oe_next    = 1'b0;
          we_next    = 1'b0;
          err_next   = 1'b1;
          rdata_next = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          err_next   = 1'b0;
          rdata_next = '0;
        end
      end
      default: begin
        oe_next = 1'b0;
        we_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oe_reg    <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      size_reg  <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      oe_reg    <= oe_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      size_reg  <= size_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  assign Mout_oe_ram        = oe_reg;
  assign Mout_we_ram        = we_reg;
  assign Mout_addr_ram      = addr_reg;
  assign Mout_Wdata_ram     = wdata_reg;
  assign Mout_data_ram_size = size_reg;
  assign rsp_rdata          = rdata_reg;
  assign rsp_err            = err_reg;

endmodule

// File: tb/tb_bambu_mem_master.sv
// Randomized bench for bambu_mem_master: byte-array responder plus transaction-level reference model.
module tb_bambu_mem_master;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_size;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          Mout_oe_ram, Mout_we_ram;
  logic [AW-1:0] Mout_addr_ram;
  logic [DW-1:0] Mout_Wdata_ram;
  logic [SW-1:0] Mout_data_ram_size;
  logic [DW-1:0] M_Rdata_ram;
  logic          M_DataRdy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bambu_mem_master #(
    .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
    .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy)
  );

  function automatic logic [7:0] mask8(input int s);
    if (s <= 0) return 8'h00;
    if (s >= 8) return 8'hFF;
    return 8'((1 << s) - 1);
  endfunction

  // Responder: read completes in the 2nd strobe cycle, write in the 1st.
  logic [7:0] dev_mem [0:127];
  logic       mem_init, stall, noise;
  int         strobe_age;
  logic       strobe;

  assign strobe      = Mout_oe_ram | Mout_we_ram;
  assign M_DataRdy   = strobe ? (!stall && (strobe_age == (Mout_oe_ram ? 1 : 0))) : noise;
  assign M_Rdata_ram = dev_mem[Mout_addr_ram];

  always @(posedge clock) begin
    strobe_age <= strobe ? strobe_age + 1 : 0;
    if (mem_init) begin
      for (int i = 0; i < 128; i++) dev_mem[i] <= 8'(i) ^ 8'h3C;
    end else if (Mout_we_ram && M_DataRdy) begin
      dev_mem[Mout_addr_ram] <= Mout_Wdata_ram & mask8(int'(Mout_data_ram_size));
    end
  end

  logic [7:0] model_mem [0:127];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [6:0] addr, input logic [7:0] wdata,
                        input logic [3:0] size, input int hold, input logic stall_en);
    logic       bad, field_ok, overlap, stable_ok, got_ready;
    logic [7:0] exp_rdata, held_rdata;
    int         exp_strobes, oe_cnt, we_cnt, lat;

    bad         = (size == 0) || (int'(size) > 8);
    exp_strobes = bad ? 0 : (stall_en ? TO : (we ? 1 : 2));
    exp_rdata   = (bad || we || stall_en) ? 8'h00 : (model_mem[addr] & mask8(int'(size)));
    if (!bad && we && !stall_en) model_mem[addr] = wdata & mask8(int'(size));

    @(negedge clock);
    stall     = stall_en;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_valid = 1'b1;
    got_ready = req_ready;
    for (int i = 0; i < 20 && !got_ready; i++) begin
      @(negedge clock);
      got_ready = req_ready;
    end
    if (!got_ready) begin
      chk("req_ready_wait", 32'(got_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_addr  = 7'($urandom);
      req_wdata = 8'($urandom);
      req_size  = 4'($urandom);
      req_we    = 1'($urandom);
      field_ok = 1'b1; overlap = 1'b0; oe_cnt = 0; we_cnt = 0; lat = 0;
      for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
        @(negedge clock);
        if (Mout_oe_ram && Mout_we_ram) overlap = 1'b1;
        if (Mout_oe_ram) oe_cnt++;
        if (Mout_we_ram) we_cnt++;
        if (strobe && (Mout_addr_ram !== addr || Mout_Wdata_ram !== wdata ||
                       Mout_data_ram_size !== size)) field_ok = 1'b0;
        if (rsp_valid) lat = cyc;
      end
      chk("latency", 32'(lat), 32'(exp_strobes + 1));
      chk("oe_cycles", 32'(oe_cnt), we ? 32'd0 : 32'(exp_strobes));
      chk("we_cycles", 32'(we_cnt), we ? 32'(exp_strobes) : 32'd0);
      chk("no_overlap", 32'(overlap), 32'd0);
      chk("bus_fields", 32'(field_ok), 32'd1);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      chk("rsp_err", 32'(rsp_err), 32'(bad || stall_en));
      chk("no_accept_in_resp", 32'(req_ready), 32'd0);
      held_rdata = rsp_rdata;
      stable_ok  = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        if (!rsp_valid || rsp_rdata !== held_rdata || rsp_err !== (bad || stall_en)) stable_ok = 1'b0;
      end
      chk("rsp_stable", 32'(stable_ok), 32'd1);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      @(negedge clock);
      chk("idle_after_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);
    end
    stall = 1'b0;
    $display("TXN we=%0d addr=%02h wdata=%02h size=%0d stall=%0d exp_rdata=%02h exp_err=%0d lat=%0d",
             we, addr, wdata, size, stall_en, exp_rdata, bad || stall_en, exp_strobes + 1);
  endtask

  always @(negedge clock) noise <= 1'($urandom);

  initial begin
    logic [6:0] ra;
    reset = 1'b0; mem_init = 1'b1; stall = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 128; i++) model_mem[i] = 8'(i) ^ 8'h3C;
    repeat (3) @(negedge clock);
    chk("rst_outputs", {25'd0, Mout_oe_ram, Mout_we_ram, rsp_valid, rsp_err, req_ready, 2'b00}, 32'd0);
    chk("rst_bus", {Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size, rsp_rdata}, 32'd0);
    mem_init = 1'b0;
    reset = 1'b1;
    #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);

    do_txn(1'b1, 7'h05, 8'hA5, 4'd8, 1, 1'b0);
    do_txn(1'b0, 7'h05, 8'h00, 4'd8, 0, 1'b0);
    do_txn(1'b0, 7'h05, 8'h00, 4'd4, 2, 1'b0);
    do_txn(1'b0, 7'h05, 8'h00, 4'd0, 0, 1'b0);
    do_txn(1'b1, 7'h10, 8'hFF, 4'd9, 1, 1'b0);
    do_txn(1'b1, 7'h7F, 8'hC3, 4'd1, 0, 1'b0);
    do_txn(1'b0, 7'h7F, 8'h00, 4'd8, 0, 1'b0);
`ifdef BAMBU_MEM_MASTER_TIMEOUT_EN
    do_txn(1'b0, 7'h22, 8'h00, 4'd8, 1, 1'b1);
    do_txn(1'b1, 7'h23, 8'h5A, 4'd8, 0, 1'b1);
`endif

    // reset abandoned in the 2nd BUSY cycle of a read
    ra = 7'($urandom);
    @(negedge clock);
    req_we = 1'b0; req_addr = ra; req_size = 4'd8; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("busy2_strobe", 32'(Mout_oe_ram), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_strobes", {30'd0, Mout_oe_ram, Mout_we_ram}, 32'd0);
    chk("midrst_rsp", {29'd0, rsp_valid, rsp_err, req_ready}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clock);
    chk("midrst_no_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);

    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), 7'($urandom), 8'($urandom), 4'($urandom_range(0, 10)),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/bambu_mem_master.md
BAMBU_MEM_MASTER -- requirements
Module: bambu_mem_master

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the byte address width of one bus channel.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width of one bus channel.
REQ-003 Parameter SIZE_W, default 4, SHALL set the access size field width, in bits-of-data units.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the timeout limit in clock cycles (used only under REQ-023).
REQ-005 Ports SHALL be:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  request accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_size  in  SIZE_W  access size in bits
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  failed access
- Mout_oe_ram  out  1  bus read strobe
- Mout_we_ram  out  1  bus write strobe
- Mout_addr_ram  out  ADDR_W  bus address
- Mout_Wdata_ram  out  DATA_W  bus write data
- Mout_data_ram_size  out  SIZE_W  bus size
- M_Rdata_ram  in  DATA_W  responder read data
- M_DataRdy  in  1  responder completion

Function
REQ-006 The FSM SHALL have the states IDLE, BUSY and RESP.
REQ-007 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-008 On a valid accept, all Mout_* outputs SHALL be registered from the req_* fields and the FSM SHALL enter BUSY; the strobe rises in the cycle after the accept.
REQ-009 In BUSY, exactly one of Mout_oe_ram or Mout_we_ram SHALL be 1, and addr, Wdata and size SHALL be held stable.
REQ-010 Both strobes SHALL never be 1 in the same cycle, under any condition.
REQ-011 In BUSY, the first rising edge with M_DataRdy=1 SHALL end the access:
- strobes go to 0 in the next cycle
- FSM enters RESP
- rsp_err=0
REQ-012 For a read, rsp_rdata SHALL equal M_Rdata_ram sampled on the completing edge, masked to the low req_size bits with the upper bits 0.
REQ-013 For a write, rsp_rdata SHALL be 0.
REQ-014 Wdata SHALL be driven unmasked; the responder applies the size mask.
REQ-015 A req_size of 0 or greater than DATA_W SHALL be rejected without a bus cycle: the FSM goes IDLE->RESP with rsp_err=1 and rsp_rdata=0.
REQ-016 rsp_valid SHALL be 1 exactly in RESP, with rsp_rdata and rsp_err stable.
REQ-017 On a rising edge with rsp_ready=1 in RESP, the FSM SHALL return to IDLE, with no back-to-back accept in that same cycle.
REQ-018 M_DataRdy outside BUSY SHALL be ignored.
REQ-019 Minimum turnaround SHALL be accept + responder latency + 2 cycles.

Reset
REQ-020 While reset=0, the block SHALL asynchronously force:
- state IDLE
- all Mout_* = 0
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
- timeout counter = 0
REQ-021 req_ready SHALL be 0 during reset and 1 on the first cycle after reset release.
REQ-022 A reset mid-access SHALL abandon the access with no response generated.

Configuration
REQ-023 With BAMBU_MEM_MASTER_TIMEOUT_EN defined:
- a counter SHALL count BUSY cycles
- if M_DataRdy is not seen within TIMEOUT_CYCLES cycles, strobes drop and the FSM enters RESP with rsp_err=1 and rsp_rdata=0
REQ-024 Without BAMBU_MEM_MASTER_TIMEOUT_EN, BUSY SHALL wait indefinitely and no timeout counter SHALL be synthesized.

Structure
REQ-025 Package bambu_mem_pkg SHALL hold:
- the state enum
- the default ADDR_W, DATA_W, SIZE_W and TIMEOUT_CYCLES constants
- a size-to-mask function
REQ-026 The timeout logic SHALL be the sub-module bambu_mem_timeout_cnt (clear, enable, expired), instantiated only under REQ-023.

Verification
REQ-027 The bench SHALL use a responder with read delay 2 and write delay 1, and SHALL cover:
- write addr 7'h05, wdata 8'hA5, size 8 -> Mout_we_ram high for 1 cycle; rsp_valid=1, rsp_err=0 on the next cycle
- read addr 7'h05, size 8 -> Mout_oe_ram high for 2 cycles; rsp_rdata=8'hA5
- read addr 7'h05, size 4 -> rsp_rdata=8'h05
- req_size=0 -> no strobe; rsp_valid one cycle after accept with rsp_err=1
- TIMEOUT_EN, TIMEOUT_CYCLES=16, M_DataRdy held 0 -> strobe drops after 16 BUSY cycles; rsp_err=1
- reset=0 in the 2nd BUSY cycle -> strobes 0 immediately, no rsp_valid; req_ready=1 after release
